// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives imem and buffers fetched words for decode.
// Latency: a word pushed at edge N is visible on op_valid in cycle N+1; a redirect costs one bubble.
// Backpressure: ip_ready=0 fills a BUF_DEPTH-entry FIFO, then fetch_pc stalls; optional range check via IFETCH_FAULT_EN.

// Small flushable FIFO; head is always visible on rd_dat, count is exact occupancy.
module ifetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     core_clk,
    input  logic                     arst_n,
    input  logic                     flush,
    input  logic                     wr_vld,
    input  logic [WIDTH-1:0]         wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [WIDTH-1:0]         rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush returns to the empty state.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_rdy)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_vld && !rd_rdy)
                count <= count + CNT_W'(1);
            else if (!wr_vld && rd_rdy)
                count <= count - CNT_W'(1);
        end
    end

    // Storage write; a slot freed by a same-cycle pop may be overwritten since the head is read before the edge.
    always_ff @(posedge core_clk) begin
        if (wr_vld && !flush)
            mem[wr_ptr] <= wr_dat;
    end
endmodule

module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2,
    parameter int          IMEM_WORDS = 32
) (
    input  logic        ip_clk,
    input  logic        ip_rst_n,
    output logic [31:0] op_instr_addr_to_imem,
    input  logic [31:0] ip_instr_from_imem,
    input  logic        ip_instr_valid,
    input  logic        ip_redirect_valid,
    input  logic [31:0] ip_redirect_pc,
    output logic [31:0] op_instr,
    output logic [31:0] op_pc,
    output logic        op_valid,
    input  logic        ip_ready,
    output logic        op_fault
);
    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
`ifdef IFETCH_FAULT_EN
    localparam int          ENTRY_W    = 65;
    localparam logic [32:0] IMEM_BYTES = 33'(IMEM_WORDS) * 33'd4;
`else
    localparam int          ENTRY_W    = 64;
`endif

    // Elaboration-time guard against unusable parameter combinations.
    if (RESET_PC[1:0] != 2'b00 || BUF_DEPTH < 2 ||
        (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || IMEM_WORDS < 1) begin : g_param_check
        $error("ifetch_unit: illegal parameter setting");
    end

    logic [31:0]        fetch_pc;
    logic [31:0]        redirect_target;
    logic               head_vld;
    logic [ENTRY_W-1:0] head_dat;
    logic [ENTRY_W-1:0] wr_dat;
    logic [CNT_W-1:0]   count;
    logic               pop;
    logic               push;
    logic               has_room;

    // Low two bits of the redirect target are dropped to keep fetch word-aligned.
    assign redirect_target = ip_redirect_pc & ~32'h3;

    // A redirect squashes whatever the FIFO would have done this cycle.
    assign pop      = head_vld & ip_ready & ~ip_redirect_valid;
    assign has_room = (count < CNT_W'(BUF_DEPTH)) | (head_vld & ip_ready);

`ifdef IFETCH_FAULT_EN
    logic halted;
    logic out_of_range;

    assign out_of_range = ({1'b0, fetch_pc} >= IMEM_BYTES);
    assign push   = ip_instr_valid & ~halted & has_room & ~ip_redirect_valid;
    assign wr_dat = out_of_range ? {fetch_pc, 32'h0, 1'b1}
                                 : {fetch_pc, ip_instr_from_imem, 1'b0};

    // Halt after pushing a fault entry; only redirect or reset resumes fetch.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n)
            halted <= 1'b0;
        else if (ip_redirect_valid)
            halted <= 1'b0;
        else if (push && out_of_range)
            halted <= 1'b1;
    end

    assign op_pc    = head_vld ? head_dat[64:33] : 32'h0;
    assign op_instr = head_vld ? head_dat[32:1]  : 32'h0;
    assign op_fault = head_vld & head_dat[0];
`else
    assign push   = ip_instr_valid & has_room & ~ip_redirect_valid;
    assign wr_dat = {fetch_pc, ip_instr_from_imem};

    assign op_pc    = head_vld ? head_dat[63:32] : 32'h0;
    assign op_instr = head_vld ? head_dat[31:0]  : 32'h0;
    assign op_fault = 1'b0;
`endif

    // Fetch PC: redirect wins, otherwise advance one word per accepted push.
    always_ff @(posedge ip_clk or negedge ip_rst_n) begin
        if (!ip_rst_n)
            fetch_pc <= RESET_PC;
        else if (ip_redirect_valid)
            fetch_pc <= redirect_target;
        else if (push)
            fetch_pc <= fetch_pc + 32'd4;
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .core_clk (ip_clk),
        .arst_n   (ip_rst_n),
        .flush    (ip_redirect_valid),
        .wr_vld   (push),
        .wr_dat   (wr_dat),
        .rd_rdy   (pop),
        .rd_vld   (head_vld),
        .rd_dat   (head_dat),
        .count    (count)
    );

    assign op_valid              = head_vld;
    assign op_instr_addr_to_imem = fetch_pc;
endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch unit: the initiator that drives word addresses into `imem` and hands fetched instructions to decode. It owns the program counter (PC) and a small prefetch FIFO that decouples the combinational `imem` read from decode back-pressure. It also accepts PC redirects from branch/jump resolution. It sits between `imem` and the decode stage of the core.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `BUF_DEPTH`, 2: prefetch FIFO entries; power of two, ≥2.
- `IMEM_WORDS`, 32: instruction memory size in 32-bit words. Used only with `IFETCH_FAULT_EN`.

Ports:
- `ip_clk`, in, 1: single clock; all state on rising edge.
- `ip_rst_n`, in, 1: asynchronous, active-low reset.
- `op_instr_addr_to_imem`, out, 32: fetch byte address; equals the internal fetch PC.
- `ip_instr_from_imem`, in, 32: instruction word returned by `imem` in the same cycle.
- `ip_instr_valid`, in, 1: `imem` response valid; push is allowed only when high.
- `ip_redirect_valid`, in, 1: redirect request.
- `ip_redirect_pc`, in, 32: redirect target; bits [1:0] ignored and forced to 0.
- `op_instr`, out, 32: instruction at the FIFO head; 0 when `op_valid`=0.
- `op_pc`, out, 32: byte address of `op_instr`; 0 when `op_valid`=0.
- `op_valid`, out, 1: FIFO non-empty.
- `ip_ready`, in, 1: decode accepts the head this cycle.
- `op_fault`, out, 1: the head entry is a fetch fault; tied 0 without the macro.

## Operation
- State: `fetch_pc`[31:0], FIFO storing {pc, instr, fault} per entry, write/read pointers, `count`[$clog2(BUF_DEPTH):0], `halted` flag (used only with the macro).
- `op_instr_addr_to_imem` = `fetch_pc`. The output is registered-driven with no combinational path from any input.
- Pop: `op_valid && ip_ready`.
- Push:
  - Condition: `ip_instr_valid && !halted && (count < BUF_DEPTH || pop)`.
  - Writes {`fetch_pc`, `ip_instr_from_imem`, 0}.
  - `fetch_pc` <= `fetch_pc` + 4, wrapping modulo 2^32.
- No push means `fetch_pc` holds.
- Simultaneous push and pop on a full FIFO is legal: `count` is unchanged and throughput is 1 instruction per cycle.
- Redirect has the highest priority. When `ip_redirect_valid` is high:
  - the FIFO is flushed (`count` <= 0, pointers reset);
  - `fetch_pc` <= {`ip_redirect_pc`[31:2], 2'b00};
  - `halted` <= 0;
  - any push or pop in that cycle is discarded. Decode must treat a head presented in a redirect cycle as squashed.
- Reset (asynchronous, mid-operation included):
  - `fetch_pc` <= `RESET_PC`, FIFO empty, `halted` <= 0.
  - Outputs: `op_instr_addr_to_imem`=`RESET_PC`, `op_valid`=0, `op_instr`=0, `op_pc`=0, `op_fault`=0.

## Timing
- Reset release before edge 0: cycle 0 addresses `RESET_PC`, push at edge 0, `op_valid`=1 in cycle 1.
- Redirect sampled at edge N: cycle N+1 addresses the target, push at edge N+1, target visible on `op_valid` in cycle N+2.
- Redirect bubble: 1 cycle of `op_valid`=0 (cycle N+1).
- Steady state with `ip_ready`=1: 1 instruction per cycle, `op_pc` increments by 4 each cycle.
- With `ip_ready`=0: the FIFO fills after BUF_DEPTH cycles, then `fetch_pc` stalls. When `ip_ready` returns, the head pops that same cycle with no bubble.
- `ip_instr_valid`=0 for k cycles inserts k cycles without a push. `fetch_pc` holds.

## Configuration
Macro: `IFETCH_FAULT_EN`.
- Defined:
  - If a push would occur with `fetch_pc` >= `IMEM_WORDS`*4, push {`fetch_pc`, 32'h0, 1} instead and set `halted` <= 1.
  - While `halted`, no further pushes occur and `fetch_pc` holds.
  - `op_fault`=1 while that entry is the head.
  - Only a redirect or reset clears `halted`.
- Undefined:
  - No range check and no `halted` logic.
  - `fetch_pc` increments freely.
  - `op_fault` is constant 0.

## Test plan
- Reset/stream: `RESET_PC`=0, `ip_ready`=1, `imem` loaded with mem[i]=i+100. Required:
  - cycle 1: `op_pc`=0, `op_instr`=100;
  - then +4 / +1 each cycle;
  - outputs are all 0 during reset.
- Back-pressure: hold `ip_ready`=0 for 5 cycles, then release. Required:
  - `count` saturates at 2 and `op_instr_addr_to_imem` freezes at 8;
  - after release, the sequence 0, 4, 8… appears with no gaps and no duplicates.
- Redirect: assert `ip_redirect_valid` with `ip_redirect_pc`=0x43 while the FIFO is full. Required:
  - next cycle `op_valid`=0 and address = 0x40;
  - the cycle after that, `op_pc`=0x40 and `op_instr`=mem[16].
- Redirect concurrent with pop and push: same-cycle `ip_ready`=1 and `ip_instr_valid`=1. Required: the FIFO is empty afterwards, with no stale entry.
- Async reset mid-stream: drop `ip_rst_n` between edges. Required:
  - outputs go to reset values immediately;
  - after release, fetch restarts at `RESET_PC`.
- `IFETCH_FAULT_EN`: `RESET_PC`=0x78, `IMEM_WORDS`=32. Required:
  - instructions at 0x78 and 0x7C are delivered normally;
  - then `op_pc`=0x80 with `op_fault`=1 and `op_instr`=0;
  - no further pushes follow;
  - a redirect to 0 resumes normal fetch.
